// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SYNC_BYTE   = 8'hA5;
  localparam logic [BYTE_W-1:0] RELOAD_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    HI,
    LO,
    WRITE,
    CSUM,
    RUN,
    ERR
  } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
) ();

  logic [BYTE_W-1:0]    RxData;
  logic                 RxValid;
  logic                 RxReady;
  logic [AddrWidth-1:0] Mem_Addr;
  logic [DataWidth-1:0] Mem_DOut;
  logic                 Mem_WE;

  // master: byte source / memory side; slave: the loader itself
  modport master (
    output RxData, RxValid,
    input  RxReady, Mem_Addr, Mem_DOut, Mem_WE
  );

  modport slave (
    input  RxData, RxValid,
    output RxReady, Mem_Addr, Mem_DOut, Mem_WE
  );

endinterface

// File: rtl/program_loader_checksum.sv
// 8-bit running-sum accumulator; zero_o looks at the value being loaded this
// cycle so the frame verdict is available on the same edge as the CSUM byte.
module loader_checksum
  import program_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [BYTE_W-1:0] dat_i,
  output logic              zero_o
);

  logic [BYTE_W-1:0] acc_q;
  logic [BYTE_W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) acc_d = '0;
    if (add_i) acc_d = acc_d + dat_i;
  end

  assign zero_o = (acc_d == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader: holds the CPU in reset, writes words into
// program memory, releases the CPU once the frame checksum verifies.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                   DataWidth = 16,
  parameter int                   AddrWidth = 8,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  program_loader_if.slave  bus,
  output logic             CpuReset,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  state_e               state_q;
  logic [BYTE_W-1:0]    count_q;
  logic [AddrWidth-1:0] index_q;
  logic [BYTE_W-1:0]    hi_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [DataWidth-1:0] mem_dout_q;
  logic                 mem_we_q;
  logic                 cpu_reset_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 error_q;

  logic                 rx_rdy;
  logic                 xfer;
  logic [BYTE_W-1:0]    rx_dat;
  logic                 csum_clr;
  logic                 csum_add;
  logic                 csum_zero;

  // The only state that cannot take a byte is the one-cycle memory write.
  assign rx_rdy = (state_q != WRITE);
  assign xfer   = bus.RxValid && rx_rdy;
  assign rx_dat = bus.RxData;

  assign csum_clr = xfer && (state_q == LEN);
  assign csum_add = xfer && (state_q inside {LEN, HI, LO, CSUM});

  loader_checksum u_checksum (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .dat_i  (rx_dat),
    .zero_o (csum_zero)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      hi_q        <= '0;
      mem_addr_q  <= BaseAddr;
      mem_dout_q  <= '0;
      mem_we_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer && rx_dat == SYNC_BYTE) begin
            state_q <= LEN;
            busy_q  <= 1'b1;
          end
        end
        LEN: begin
          if (xfer) begin
            count_q <= rx_dat;
            index_q <= '0;
            state_q <= (rx_dat != '0) ? HI : CSUM;
          end
        end
        HI: begin
          if (xfer) begin
            hi_q    <= rx_dat;
            state_q <= LO;
          end
        end
        LO: begin
          if (xfer) begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= BaseAddr + index_q;
            mem_dout_q <= DataWidth'({hi_q, rx_dat});
            state_q    <= WRITE;
          end
        end
        WRITE: begin
          // count_q is at least 1 here; reaching 1 means this was the last word
          index_q <= index_q + AddrWidth'(1);
          count_q <= count_q - 8'd1;
          state_q <= (count_q == 8'd1) ? CSUM : HI;
        end
        CSUM: begin
          if (xfer) begin
            busy_q <= 1'b0;
            if (csum_zero) begin
              state_q     <= RUN;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (xfer && rx_dat == RELOAD_BYTE) begin
            state_q     <= IDLE;
            cpu_reset_q <= 1'b1;
            error_q     <= 1'b0;
          end
        end
        ERR: begin
          if (xfer && rx_dat == SYNC_BYTE) begin
            state_q <= LEN;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.RxReady  = rx_rdy;
  assign bus.Mem_Addr = mem_addr_q;
  assign bus.Mem_DOut = mem_dout_q;
  assign bus.Mem_WE   = mem_we_q;
  assign CpuReset     = cpu_reset_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign Error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; a second instance at the top of the
// address space shares the byte stream to exercise address wrap.
module tb_program_loader;

  logic Clk;
  logic Reset;

  program_loader_if #(.DataWidth(16), .AddrWidth(8)) bif ();
  program_loader_if #(.DataWidth(16), .AddrWidth(8)) wif ();

  logic cpu_reset, busy, done, error;
  logic w_cpu_reset, w_busy, w_done, w_error;

  assign wif.RxData  = bif.RxData;
  assign wif.RxValid = bif.RxValid;

  program_loader #(.DataWidth(16), .AddrWidth(8), .BaseAddr(8'h00)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bif),
    .CpuReset (cpu_reset),
    .Busy     (busy),
    .Done     (done),
    .Error    (error)
  );

  program_loader #(.DataWidth(16), .AddrWidth(8), .BaseAddr(8'hFF)) dut_wrap (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (wif),
    .CpuReset (w_cpu_reset),
    .Busy     (w_busy),
    .Done     (w_done),
    .Error    (w_error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc++;

  logic [23:0] wr_q[$];
  logic [23:0] wwr_q[$];
  int done_cnt  = 0;
  int rdy_viol  = 0;
  int pair_diff = 0;

  always @(negedge Clk) begin
    if (bif.Mem_WE) begin
      wr_q.push_back({bif.Mem_Addr, bif.Mem_DOut});
      if (bif.RxReady) rdy_viol++;
    end
    if (wif.Mem_WE) wwr_q.push_back({wif.Mem_Addr, wif.Mem_DOut});
    if (done) done_cnt++;
    if (bif.RxReady != wif.RxReady || done != w_done || cpu_reset != w_cpu_reset ||
        busy != w_busy || error != w_error)
      pair_diff++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte is transferred.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    bif.RxData  = b;
    bif.RxValid = 1'b1;
    n = 0;
    while (!bif.RxReady && n < 16) begin
      @(negedge Clk);
      n++;
    end
    if (!bif.RxReady) check("rdy_timeout", 32'(bif.RxReady), 32'd1);
    @(negedge Clk);
    if (gap) begin
      bif.RxValid = 1'b0;
      @(negedge Clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit gap);
    foreach (f[i]) send_byte(f[i], gap);
    bif.RxValid = 1'b0;
  endtask

  logic [7:0] good_fr[$] = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
  logic [7:0] bad_fr[$]  = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
  logic [7:0] good_tail[$] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
  logic [7:0] empty_fr[$] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
  logic [7:0] part_fr[$]  = '{8'hA5, 8'h03, 8'h11, 8'h22};

  int wb, wwb, db, c0;

  task automatic check_good_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_q.size() - wb), 32'd2);
    check({tag, "_wr0"}, 32'(wr_q[wb]), 32'h001234);
    check({tag, "_wr1"}, 32'(wr_q[wb+1]), 32'h01ABCD);
    check({tag, "_done"}, 32'(done_cnt - db), 32'd1);
  endtask

  task automatic snap;
    wb  = wr_q.size();
    wwb = wwr_q.size();
    db  = done_cnt;
  endtask

  initial begin
    Reset       = 1'b1;
    bif.RxData  = 8'h00;
    bif.RxValid = 1'b0;
    idle(3);
    Reset = 1'b0;

    check("rst_cpureset", 32'(cpu_reset), 32'd1);
    check("rst_we",       32'(bif.Mem_WE), 32'd0);
    check("rst_addr",     32'(bif.Mem_Addr), 32'h00);
    check("rst_dout",     32'(bif.Mem_DOut), 32'h0000);
    check("rst_busy",     32'(busy), 32'd0);
    check("rst_done",     32'(done), 32'd0);
    check("rst_error",    32'(error), 32'd0);
    check("rst_rdy",      32'(bif.RxReady), 32'd1);
    check("rst_waddr",    32'(wif.Mem_Addr), 32'hFF);

    // good load, back to back; also checks minimum frame time
    snap();
    c0 = cyc;
    send_byte(8'hA5, 1'b0);
    check("good_busy_len", 32'(busy), 32'd1);
    send_frame(good_fr[1:$], 1'b0);
    check("good_cycles",   32'(cyc - c0), 32'd9);
    check("good_done",     32'(done), 32'd1);
    check("good_cpureset", 32'(cpu_reset), 32'd0);
    check("good_error",    32'(error), 32'd0);
    check("good_busy",     32'(busy), 32'd0);
    idle(3);
    check_good_writes("good");
    check("wrap_nwr", 32'(wwr_q.size() - wwb), 32'd2);
    check("wrap_wr0", 32'(wwr_q[wwb]), 32'hFF1234);
    check("wrap_wr1", 32'(wwr_q[wwb+1]), 32'h00ABCD);

    // reload: ordinary bytes ignored while running
    send_frame('{8'h77}, 1'b0);
    check("run_ignore_cpureset", 32'(cpu_reset), 32'd0);
    send_frame('{8'h5A}, 1'b0);
    check("reload_cpureset", 32'(cpu_reset), 32'd1);
    check("reload_busy",     32'(busy), 32'd0);

    // bad checksum then recovery
    snap();
    send_frame(bad_fr, 1'b0);
    check("bad_error",    32'(error), 32'd1);
    check("bad_cpureset", 32'(cpu_reset), 32'd1);
    check("bad_done",     32'(done), 32'd0);
    idle(3);
    check("bad_cpu_held", 32'(cpu_reset), 32'd1);
    check("bad_ndone",    32'(done_cnt - db), 32'd0);

    snap();
    send_frame('{8'h55}, 1'b0);
    check("err_noise_error", 32'(error), 32'd1);
    send_frame('{8'hA5, 8'h02}, 1'b0);
    check("err_clear_at_len", 32'(error), 32'd0);
    check("err_busy",         32'(busy), 32'd1);
    send_frame(good_tail, 1'b0);
    check("recov_cpureset", 32'(cpu_reset), 32'd0);
    idle(3);
    check_good_writes("recov");

    // empty frame behind noise
    send_frame('{8'h5A}, 1'b0);
    snap();
    c0 = cyc;
    send_frame(empty_fr, 1'b0);
    check("empty_cycles",   32'(cyc - c0), 32'd5);
    check("empty_done",     32'(done), 32'd1);
    check("empty_cpureset", 32'(cpu_reset), 32'd0);
    idle(3);
    check("empty_nwr", 32'(wr_q.size() - wb), 32'd0);

    // valid toggling every other cycle
    send_frame('{8'h5A}, 1'b0);
    snap();
    send_frame(good_fr, 1'b1);
    idle(3);
    check_good_writes("gap");
    check("gap_cpureset", 32'(cpu_reset), 32'd0);

    // reset during the first write of a 3-word frame
    send_frame('{8'h5A}, 1'b0);
    snap();
    send_frame(part_fr, 1'b0);
    check("mid_we", 32'(bif.Mem_WE), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("mid_cpureset", 32'(cpu_reset), 32'd1);
    check("mid_busy",     32'(busy), 32'd0);
    check("mid_we_off",   32'(bif.Mem_WE), 32'd0);
    check("mid_rdy",      32'(bif.RxReady), 32'd1);
    idle(4);
    check("mid_nwr", 32'(wr_q.size() - wb), 32'd1);
    check("mid_wr0", 32'(wr_q[wb]), 32'h001122);

    snap();
    send_frame(good_fr, 1'b0);
    check("after_rst_cpureset", 32'(cpu_reset), 32'd0);
    idle(3);
    check_good_writes("after_rst");

    check("rdy_during_write", 32'(rdy_viol), 32'd0);
    check("pair_lockstep",    32'(pair_diff), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
